// File: rtl/equiv_monitor.sv
// equiv_monitor: cycle-level equivalence monitor for two DUT output buses with latency alignment,
// warm-up masking, saturating mismatch counting and first-failure capture. Optional: EQUIV_MONITOR_ASSERT_EN.
module equiv_monitor #(
    parameter int WIDTH  = 91,
    parameter int LAT_A  = 0,
    parameter int LAT_B  = 0,
    parameter int WARMUP = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] y_a,
    input  logic [WIDTH-1:0] y_b,
    input  logic             clear,
    output logic             mismatch,
    output logic             sticky_fail,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_stamp,
    output logic [WIDTH-1:0] first_diff,
    output logic             armed
);

    typedef enum logic [1:0] {
        WARM   = 2'd0,
        ARMED  = 2'd1,
        FAILED = 2'd2
    } state_t;

    localparam int unsigned DA = LAT_A;
    localparam int unsigned DB = LAT_B;
    localparam logic [7:0]       WARM_INIT = 8'(WARMUP);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [7:0]       warm_cnt;
    logic [CNT_W-1:0] stamp;

    logic             va_d;
    logic             vb_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;

    logic             slot;
    logic [WIDTH-1:0] diff;
    logic             fail_now;
    logic             armed_cmp;
    logic             count_now;

    // Side A alignment: depth 0 feeds the compare stage directly.
    generate
        if (LAT_A == 0) begin : g_a_pass
            assign va_d = valid_in;
            assign a_d  = y_a;
        end else begin : g_a_pipe
            logic [DA-1:0]    v_pipe;
            logic [WIDTH-1:0] d_pipe [DA];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_pipe <= '0;
                    for (int unsigned i = 0; i < DA; i++) begin
                        d_pipe[i] <= '0;
                    end
                end else begin
                    v_pipe[0] <= valid_in & ~clear;
                    d_pipe[0] <= y_a;
                    for (int unsigned i = 1; i < DA; i++) begin
                        v_pipe[i] <= v_pipe[i-1] & ~clear;
                        d_pipe[i] <= d_pipe[i-1];
                    end
                end
            end

            assign va_d = v_pipe[DA-1];
            assign a_d  = d_pipe[DA-1];
        end
    endgenerate

    generate
        if (LAT_B == 0) begin : g_b_pass
            assign vb_d = valid_in;
            assign b_d  = y_b;
        end else begin : g_b_pipe
            logic [DB-1:0]    v_pipe;
            logic [WIDTH-1:0] d_pipe [DB];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_pipe <= '0;
                    for (int unsigned i = 0; i < DB; i++) begin
                        d_pipe[i] <= '0;
                    end
                end else begin
                    v_pipe[0] <= valid_in & ~clear;
                    d_pipe[0] <= y_b;
                    for (int unsigned i = 1; i < DB; i++) begin
                        v_pipe[i] <= v_pipe[i-1] & ~clear;
                        d_pipe[i] <= d_pipe[i-1];
                    end
                end
            end

            assign vb_d = v_pipe[DB-1];
            assign b_d  = d_pipe[DB-1];
        end
    endgenerate

    always_comb begin
        slot      = va_d & vb_d;
        diff      = a_d ^ b_d;
        fail_now  = |diff;
        armed_cmp = ((state == ARMED) || (state == FAILED)) && slot;
        count_now = armed_cmp && fail_now && !clear;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WARM;
        end else begin
            state <= state_nx;
        end
    end

    // Leave WARM on the slot that drains the counter, so WARMUP slots are masked exactly.
    always_comb begin
        state_nx = state;
        unique case (state)
            WARM: begin
                if ((warm_cnt == '0) || (slot && (warm_cnt == 8'd1))) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (count_now) begin
                    state_nx = FAILED;
                end
            end
            FAILED: begin
                state_nx = FAILED;
            end
            default: begin
                state_nx = WARM;
            end
        endcase
        if (clear) begin
            state_nx = WARM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp        <= '0;
            warm_cnt     <= WARM_INIT;
            mismatch     <= 1'b0;
            sticky_fail  <= 1'b0;
            mismatch_cnt <= '0;
            first_stamp  <= '0;
            first_diff   <= '0;
        end else begin
            if (stamp != '1) begin
                stamp <= stamp + ONE_C;
            end
            if (clear) begin
                warm_cnt     <= WARM_INIT;
                mismatch     <= 1'b0;
                sticky_fail  <= 1'b0;
                mismatch_cnt <= '0;
                first_stamp  <= '0;
                first_diff   <= '0;
            end else begin
                mismatch <= count_now;
                if ((state == WARM) && slot && (warm_cnt != '0)) begin
                    warm_cnt <= warm_cnt - 8'd1;
                end
                if (count_now) begin
                    if (mismatch_cnt != '1) begin
                        mismatch_cnt <= mismatch_cnt + ONE_C;
                    end
                    if (state == ARMED) begin
                        first_stamp <= stamp;
                        first_diff  <= diff;
                        sticky_fail <= 1'b1;
                    end
                end
            end
        end
    end

    assign armed = (state == ARMED) || (state == FAILED);

`ifdef EQUIV_MONITOR_ASSERT_EN
    always @(posedge clk) begin
        assert (!(armed_cmp && fail_now));
    end
`endif

endmodule

// File: tb/tb_equiv_monitor.sv
// Self-checking bench for equiv_monitor: three configurations driven with random data, compared each
// cycle against a slot-counting reference model built from delayed-input history.
`timescale 1ns/1ps
module tb_equiv_monitor;

    localparam int W = 91;
    localparam int N = 3;
    localparam int M = 3;

    int LA [N] = '{0, 2, 1};
    int LB [N] = '{0, 0, 3};
    int WU [N] = '{4, 4, 0};
    int CW [N] = '{16, 16, 3};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic valid_in = 1'b0;
    logic [W-1:0] ya [N];
    logic [W-1:0] yb [N];

    logic mm0, mm1, mm2, sf0, sf1, sf2, ar0, ar1, ar2;
    logic [15:0] mc0, mc1, fs0, fs1;
    logic [2:0]  mc2, fs2;
    logic [W-1:0] fd0, fd1, fd2;

    logic o_mism [N];
    logic o_sticky [N];
    logic o_armed [N];
    logic [15:0] o_cnt [N];
    logic [15:0] o_fst [N];
    logic [W-1:0] o_fdiff [N];

    always #5 clk = ~clk;

    equiv_monitor #(.WIDTH(W), .LAT_A(0), .LAT_B(0), .WARMUP(4), .CNT_W(16)) d0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .y_a(ya[0]), .y_b(yb[0]), .clear(clear),
        .mismatch(mm0), .sticky_fail(sf0), .mismatch_cnt(mc0), .first_stamp(fs0),
        .first_diff(fd0), .armed(ar0));

    equiv_monitor #(.WIDTH(W), .LAT_A(2), .LAT_B(0), .WARMUP(4), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .y_a(ya[1]), .y_b(yb[1]), .clear(clear),
        .mismatch(mm1), .sticky_fail(sf1), .mismatch_cnt(mc1), .first_stamp(fs1),
        .first_diff(fd1), .armed(ar1));

    equiv_monitor #(.WIDTH(W), .LAT_A(1), .LAT_B(3), .WARMUP(0), .CNT_W(3)) d2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .y_a(ya[2]), .y_b(yb[2]), .clear(clear),
        .mismatch(mm2), .sticky_fail(sf2), .mismatch_cnt(mc2), .first_stamp(fs2),
        .first_diff(fd2), .armed(ar2));

    always_comb begin
        o_mism[0] = mm0;  o_mism[1] = mm1;  o_mism[2] = mm2;
        o_sticky[0] = sf0; o_sticky[1] = sf1; o_sticky[2] = sf2;
        o_armed[0] = ar0; o_armed[1] = ar1; o_armed[2] = ar2;
        o_cnt[0] = mc0;   o_cnt[1] = mc1;   o_cnt[2] = {13'b0, mc2};
        o_fst[0] = fs0;   o_fst[1] = fs1;   o_fst[2] = {13'b0, fs2};
        o_fdiff[0] = fd0; o_fdiff[1] = fd1; o_fdiff[2] = fd2;
    end

    int checks = 0;
    int failures = 0;

    // Reference model: cycle index since reset, last clear cycle, per-instance slot counts.
    int t;
    int last_clr;
    int m_cnt [N];
    int m_fst [N];
    int m_slots [N];
    bit m_mism [N];
    bit m_sticky [N];
    bit m_armed [N];
    logic [W-1:0] m_fdiff [N];

    bit h_v [16];
    logic [W-1:0] h_a [N][16];
    logic [W-1:0] h_b [N][16];
    logic [W-1:0] zq [M+1];
    logic [W-1:0] flip [N];
    bit raw1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        last_clr = -1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_fst[i] = 0; m_slots[i] = 0;
            m_mism[i] = 0; m_sticky[i] = 0; m_armed[i] = 0; m_fdiff[i] = '0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] diff;
        int sa, sb, lim;
        h_v[t % 16] = valid_in;
        for (int i = 0; i < N; i++) begin
            h_a[i][t % 16] = ya[i];
            h_b[i][t % 16] = yb[i];
        end
        for (int i = 0; i < N; i++) begin
            lim = (1 << CW[i]) - 1;
            m_mism[i] = 0;
            if (clear) begin
                m_cnt[i] = 0; m_sticky[i] = 0; m_fst[i] = 0; m_fdiff[i] = '0; m_slots[i] = 0;
            end else begin
                sa = t - LA[i];
                sb = t - LB[i];
                if (sa > last_clr && sb > last_clr) begin
                    if (h_v[sa % 16] && h_v[sb % 16]) begin
                        diff = h_a[i][sa % 16] ^ h_b[i][sb % 16];
                        if (m_slots[i] >= WU[i] && t != last_clr + 1 && diff != '0) begin
                            m_mism[i] = 1;
                            if (m_cnt[i] < lim) m_cnt[i]++;
                            if (!m_sticky[i]) begin
                                m_sticky[i] = 1;
                                m_fst[i] = (t < lim) ? t : lim;
                                m_fdiff[i] = diff;
                            end
                        end
                        m_slots[i]++;
                    end
                end
            end
        end
        if (clear) last_clr = t;
        t++;
        for (int i = 0; i < N; i++) begin
            m_armed[i] = (t > last_clr + 1) && (m_slots[i] >= WU[i]);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            check($sformatf("d%0d.mismatch@%0d", i, t), W'(o_mism[i]), W'(m_mism[i]));
            check($sformatf("d%0d.sticky@%0d", i, t), W'(o_sticky[i]), W'(m_sticky[i]));
            check($sformatf("d%0d.armed@%0d", i, t), W'(o_armed[i]), W'(m_armed[i]));
            check($sformatf("d%0d.cnt@%0d", i, t), W'(o_cnt[i]), W'(m_cnt[i]));
            check($sformatf("d%0d.first_stamp@%0d", i, t), W'(o_fst[i]), W'(m_fst[i]));
            check($sformatf("d%0d.first_diff@%0d", i, t), o_fdiff[i], m_fdiff[i]);
        end
    endtask

    // Drive one cycle at a falling edge; aligned B equals aligned A unless flip is set.
    task automatic step(input bit clr, input bit v);
        for (int k = M; k > 0; k--) zq[k] = zq[k-1];
        zq[0] = W'({$urandom, $urandom, $urandom});
        for (int i = 0; i < N; i++) begin
            ya[i] = zq[M - LA[i]];
            yb[i] = zq[M - LB[i]] ^ flip[i];
        end
        if (raw1) yb[1] = ya[1];
        clear = clr;
        valid_in = v;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst.d%0d.mismatch", i), W'(o_mism[i]), '0);
            check($sformatf("rst.d%0d.sticky", i), W'(o_sticky[i]), '0);
            check($sformatf("rst.d%0d.armed", i), W'(o_armed[i]), '0);
            check($sformatf("rst.d%0d.cnt", i), W'(o_cnt[i]), '0);
            check($sformatf("rst.d%0d.first_stamp", i), W'(o_fst[i]), '0);
            check($sformatf("rst.d%0d.first_diff", i), o_fdiff[i], '0);
        end
        @(negedge clk);
        rst = 1'b0;
        clear = 1'b0;
        valid_in = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [W-1:0] one;
        one = 1;
        raw1 = 0;
        for (int k = 0; k <= M; k++) zq[k] = '0;
        for (int i = 0; i < N; i++) begin
            flip[i] = '0; ya[i] = '0; yb[i] = '0;
        end
        @(negedge clk);
        do_reset();

        // Equal streams, one flipped bit at cycle 10 on d0; d2 always differs (saturation).
        flip[2] = '1;
        for (int c = 0; c < 20; c++) begin
            flip[0] = (c == 10) ? one : '0;
            step(1'b0, 1'b1);
        end
        check("dir.d0.cnt", W'(mc0), W'(1));
        check("dir.d0.first_stamp", W'(fs0), W'(10));
        check("dir.d0.first_diff", fd0, one);
        check("dir.d0.sticky", W'(sf0), W'(1));
        check("dir.d1.cnt", W'(mc1), '0);
        check("dir.d2.cnt_sat", W'(mc2), W'(7));
        check("dir.d2.first_stamp", W'(fs2), W'(3));

        // Mismatch inside warm-up is ignored; d1 without latency offset fails once armed.
        do_reset();
        flip[2] = '0;
        raw1 = 1;
        for (int c = 0; c < 10; c++) begin
            flip[0] = (c == 2) ? (one << 7) : '0;
            step(1'b0, 1'b1);
        end
        check("warm.d0.sticky", W'(sf0), '0);
        check("warm.d0.cnt", W'(mc0), '0);
        check("raw.d1.sticky", W'(sf1), W'(1));
        raw1 = 0;

        // clear wins over a coincident failing slot, then rst while FAILED.
        flip[0] = one;
        step(1'b1, 1'b1);
        flip[0] = '0;
        check("clr.d0.cnt", W'(mc0), '0);
        check("clr.d0.mismatch", W'(mm0), '0);
        check("clr.d0.armed", W'(ar0), '0);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b1);
        flip[0] = one << 40;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        flip[0] = '0;
        check("clr.d0.refail", W'(sf0), W'(1));
        do_reset();

        // Randomized traffic with sparse bit flips, clears and resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                flip[i] = ($urandom_range(7) == 0) ? (one << $urandom_range(W-1)) : '0;
            end
            step($urandom_range(39) == 0, $urandom_range(9) != 0);
            if (c % 200 == 199) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
